bw_measure_ctrl: RTL and testbench
==================================

# bw_measure_ctrl

Sequencer for the occupied-bandwidth measurement path. On each new accumulator frame it launches the left-edge and right-edge finders in parallel and collects both edge frequencies. It then derives bandwidth and centre bin and presents one result per frame on a valid/ready interface to the reporting logic. It also supervises the finders with a timeout, counts frames dropped while busy, and flags inconsistent edge pairs.

## Interface
- F_WIDTH, 9: width of edge, bandwidth and centre frequencies (bins)
- TIMEOUT_CYCLES, 64: max cycles to wait for both edge valids after launch (≥2)
- DECIM, 1: measure every DECIM-th accepted frame (≥1)
- DROP_CNT_WIDTH, 8: width of saturating drop counter
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, asynchronous, active-high
- enable_i  in  1  allow new measurements to launch
- frame_ready_i  in  1  one-cycle pulse: accumulator frame updated (dB values stable until next pulse)
- left_start_o  out  1  one-cycle launch pulse to left-edge finder
- left_valid_i  in  1  left finder result valid (single-cycle pulse)
- f_left_i  in  F_WIDTH  left edge frequency
- right_start_o  out  1  one-cycle launch pulse to right-edge finder
- right_valid_i  in  1  right finder result valid (single-cycle pulse)
- f_right_i  in  F_WIDTH  right edge frequency
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer accepts result
- bw_o  out  F_WIDTH  f_right − f_left (0 on error)
- center_o  out  F_WIDTH  floor((f_left + f_right)/2) (0 on error)
- err_o  out  2  bit0 timeout, bit1 edge order (f_right < f_left); qualified by res_valid_o
- busy_o  out  1  state ≠ IDLE
- drop_cnt_o  out  DROP_CNT_WIDTH  saturating count of frames ignored while busy

## Operation
- States: IDLE, LAUNCH, WAIT, CALC, HOLD.
- IDLE: on frame_ready_i & enable_i, decimation counter checked. If count == DECIM−1, count := 0 and → LAUNCH; else count++ and stay. DECIM=1 launches every frame. frame_ready_i with enable_i low: ignored, not counted.
- LAUNCH (1 cycle): left_start_o = right_start_o = 1. Clear sticky flags got_l/got_r. Load timeout counter with TIMEOUT_CYCLES. → WAIT.
- WAIT: left_valid_i sets got_l and captures f_left_i; right_valid_i likewise for got_r / f_right_i. Both may arrive in the same cycle. A second valid from the same side overwrites the captured value. Counter decrements each cycle.
  - got_l & got_r (including a valid arriving this cycle) → CALC.
  - Counter reaches 0 with a side missing → CALC with timeout flag set.
- CALC (1 cycle): compute result in registers. → HOLD.
  - Timeout: bw = 0, center = 0, err = 01.
  - Else if f_right < f_left: bw = 0, center = 0, err = 10.
  - Else: bw = f_right − f_left, center = (f_left + f_right) >> 1 using an F_WIDTH+1-bit sum, err = 00.
- HOLD: res_valid_o = 1, outputs stable. res_ready_i → IDLE. Ready may be held high before valid.
- frame_ready_i in any state other than IDLE: drop_cnt++ (saturates at all-ones) if enable_i. Never queued.
- enable_i deasserted mid-measurement: current measurement completes normally.
- Finder valids in IDLE, LAUNCH, CALC or HOLD: ignored.

## Timing
- Reset values: all outputs 0 (res_valid_o=0, start pulses 0, busy_o=0, drop_cnt_o=0, bw/center/err=0). State IDLE, decimation count 0.
- Reset asserted mid-operation: immediate return to IDLE. Pending result discarded; drop count cleared.
- frame_ready_i at cycle t (launching) → start pulses at t+1.
- Last required valid at cycle v → CALC at v+1 → res_valid_o from v+2.
- Timeout: WAIT entered at t+2; CALC at t+2+TIMEOUT_CYCLES if incomplete.
- Handshake: transfer when res_valid_o & res_ready_i. Earliest next launch is from a frame_ready_i in the cycle after transfer.
- Outputs registered; no combinational path from inputs to outputs.

## Test plan
- Nominal: DECIM=1, frame pulse at t, left valid f_left=100 at t+5, right valid f_right=140 at t+9, ready high → starts at t+1, res_valid at t+11, bw=40, center=120, err=00, one-cycle transfer.
- Same-cycle valids plus backpressure: f_left=10, f_right=11 together; ready low for 5 cycles → bw=1, center=10, outputs stable while held; extra frame pulses during hold give drop_cnt_o=number of pulses.
- Timeout: only left valid returned, TIMEOUT_CYCLES=64 → res_valid at t+67, err=01, bw=0, center=0.
- Order error: f_left=200, f_right=150 → err=10, bw=0, center=0; max values f_left=f_right=511 → bw=0, center=511, no overflow.
- Decimation/enable: DECIM=3, 6 frames with enable high → exactly 2 launches (frames 3 and 6); frames with enable low produce no launch and no drop count.
- Reset mid-WAIT: rst_i pulse asynchronously between clock edges → busy_o, res_valid_o, drop_cnt_o drop to 0 immediately; later finder valids are ignored; next frame launches normally.

Source files
------------

// File: rtl/bw_measure_ctrl.sv
// bw_measure_ctrl: launches the left/right edge finders once per (decimated) frame,
// turns the two edge bins into bandwidth and centre, and holds one result per frame.
module bw_measure_ctrl #(
  parameter int F_WIDTH        = 9,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DECIM          = 1,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      frame_ready_i,
  output logic                      left_start_o,
  input  logic                      left_valid_i,
  input  logic [F_WIDTH-1:0]        f_left_i,
  output logic                      right_start_o,
  input  logic                      right_valid_i,
  input  logic [F_WIDTH-1:0]        f_right_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [F_WIDTH-1:0]        bw_o,
  output logic [F_WIDTH-1:0]        center_o,
  output logic [1:0]                err_o,
  output logic                      busy_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CALC,
    S_HOLD
  } state_e;

  state_e                    state_q, state_d;
  logic [DEC_W-1:0]          dec_q, dec_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic                      got_l_q, got_l_d;
  logic                      got_r_q, got_r_d;
  logic [F_WIDTH-1:0]        f_left_q, f_left_d;
  logic [F_WIDTH-1:0]        f_right_q, f_right_d;
  logic                      timeout_q, timeout_d;
  logic [F_WIDTH-1:0]        bw_q, bw_d;
  logic [F_WIDTH-1:0]        center_q, center_d;
  logic [1:0]                err_q, err_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      start_q;
  logic                      valid_q;
  logic                      busy_q;

  logic                      seen_l;
  logic                      seen_r;
  logic [F_WIDTH:0]          edge_sum;

  assign seen_l   = got_l_q | left_valid_i;
  assign seen_r   = got_r_q | right_valid_i;
  // One extra bit keeps the centre correct when both edges sit at the top bin.
  assign edge_sum = {1'b0, f_left_q} + {1'b0, f_right_q};

  always_comb begin
    state_d   = state_q;
    dec_d     = dec_q;
    to_cnt_d  = to_cnt_q;
    got_l_d   = got_l_q;
    got_r_d   = got_r_q;
    f_left_d  = f_left_q;
    f_right_d = f_right_q;
    timeout_d = timeout_q;
    bw_d      = bw_q;
    center_d  = center_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (frame_ready_i && enable_i) begin
          if (dec_q == DEC_LAST) begin
            dec_d   = '0;
            state_d = S_LAUNCH;
          end else begin
            dec_d = dec_q + DEC_W'(1);
          end
        end
      end

      S_LAUNCH: begin
        got_l_d   = 1'b0;
        got_r_d   = 1'b0;
        timeout_d = 1'b0;
        to_cnt_d  = TO_LOAD;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        if (left_valid_i) begin
          got_l_d  = 1'b1;
          f_left_d = f_left_i;
        end
        if (right_valid_i) begin
          got_r_d   = 1'b1;
          f_right_d = f_right_i;
        end
        to_cnt_d = to_cnt_q - TO_W'(1);
        // A valid landing in the final window cycle still wins over the timeout.
        if (seen_l && seen_r) begin
          state_d = S_CALC;
        end else if (to_cnt_q == TO_W'(1)) begin
          timeout_d = 1'b1;
          state_d   = S_CALC;
        end
      end

      S_CALC: begin
        if (timeout_q) begin
          bw_d     = '0;
          center_d = '0;
          err_d    = 2'b01;
        end else if (f_right_q < f_left_q) begin
          bw_d     = '0;
          center_d = '0;
          err_d    = 2'b10;
        end else begin
          bw_d     = f_right_q - f_left_q;
          center_d = F_WIDTH'(edge_sum >> 1);
          err_d    = 2'b00;
        end
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if ((state_q != S_IDLE) && frame_ready_i && enable_i && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      dec_q     <= '0;
      to_cnt_q  <= '0;
      got_l_q   <= 1'b0;
      got_r_q   <= 1'b0;
      f_left_q  <= '0;
      f_right_q <= '0;
      timeout_q <= 1'b0;
      bw_q      <= '0;
      center_q  <= '0;
      err_q     <= '0;
      drop_q    <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dec_q     <= dec_d;
      to_cnt_q  <= to_cnt_d;
      got_l_q   <= got_l_d;
      got_r_q   <= got_r_d;
      f_left_q  <= f_left_d;
      f_right_q <= f_right_d;
      timeout_q <= timeout_d;
      bw_q      <= bw_d;
      center_q  <= center_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      start_q   <= (state_d == S_LAUNCH);
      valid_q   <= (state_d == S_HOLD);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign left_start_o  = start_q;
  assign right_start_o = start_q;
  assign res_valid_o   = valid_q;
  assign bw_o          = bw_q;
  assign center_o      = center_q;
  assign err_o         = err_q;
  assign busy_o        = busy_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_bw_measure_ctrl.sv
// tb_bw_measure_ctrl: directed scenarios for bw_measure_ctrl, checked every cycle against a
// timestamp-based transaction model, with literal expectations pinning key results.
module tb_bw_measure_ctrl;

  localparam int FW     = 9;
  localparam int TO     = 64;
  localparam int MDECIM = 1;
  localparam int DW     = 8;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          frameReady = 1'b0;
  logic          leftValid = 1'b0;
  logic          rightValid = 1'b0;
  logic          resReady = 1'b0;
  logic [FW-1:0] fLeft = '0;
  logic [FW-1:0] fRight = '0;

  logic          leftStart, rightStart, resValid, busy;
  logic [FW-1:0] bw, center;
  logic [1:0]    err;
  logic [DW-1:0] dropCnt;

  logic          d3LeftStart, d3RightStart, d3ResValid, d3Busy;
  logic [FW-1:0] d3Bw, d3Center;
  logic [1:0]    d3Err;
  logic [DW-1:0] d3Drop;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int d3Starts = 0;

  // Transaction model state: timestamps instead of a state machine.
  bit mActive;
  int mLaunch, mDone, mL, mR, mBw, mCenter, mErr, mDrops, mAccepted;
  bit mGotL, mGotR;

  bw_measure_ctrl #(.F_WIDTH(FW), .TIMEOUT_CYCLES(TO), .DECIM(MDECIM), .DROP_CNT_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .frame_ready_i(frameReady),
    .left_start_o(leftStart), .left_valid_i(leftValid), .f_left_i(fLeft),
    .right_start_o(rightStart), .right_valid_i(rightValid), .f_right_i(fRight),
    .res_valid_o(resValid), .res_ready_i(resReady), .bw_o(bw), .center_o(center),
    .err_o(err), .busy_o(busy), .drop_cnt_o(dropCnt)
  );

  bw_measure_ctrl #(.F_WIDTH(FW), .TIMEOUT_CYCLES(TO), .DECIM(3), .DROP_CNT_WIDTH(DW)) dut3 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .frame_ready_i(frameReady),
    .left_start_o(d3LeftStart), .left_valid_i(leftValid), .f_left_i(fLeft),
    .right_start_o(d3RightStart), .right_valid_i(rightValid), .f_right_i(fRight),
    .res_valid_o(d3ResValid), .res_ready_i(resReady), .bw_o(d3Bw), .center_o(d3Center),
    .err_o(d3Err), .busy_o(d3Busy), .drop_cnt_o(d3Drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic modelReset();
    mActive   = 1'b0;
    mLaunch   = -10;
    mDone     = -1;
    mGotL     = 1'b0;
    mGotR     = 1'b0;
    mL        = 0;
    mR        = 0;
    mBw       = 0;
    mCenter   = 0;
    mErr      = 0;
    mDrops    = 0;
    mAccepted = 0;
  endtask

  task automatic modelResult(input bit timedOut);
    if (timedOut) begin
      mBw = 0; mCenter = 0; mErr = 1;
    end else if (mR < mL) begin
      mBw = 0; mCenter = 0; mErr = 2;
    end else begin
      mBw = mR - mL; mCenter = (mL + mR) / 2; mErr = 0;
    end
  endtask

  // Compare the outputs of the current cycle, then fold in this cycle's inputs.
  task automatic modelStep();
    int n;
    bit expValid;
    n = cyc;
    if (rst) begin
      modelReset();
      checkOutput("rst busy", int'(busy), 0);
      checkOutput("rst start", int'(leftStart | rightStart), 0);
      checkOutput("rst valid", int'(resValid), 0);
      checkOutput("rst drop", int'(dropCnt), 0);
      checkOutput("rst result", int'({bw, center, err}), 0);
      return;
    end
    expValid = mActive && (mDone >= 0) && (n >= mDone);
    checkOutput("busy", int'(busy), int'(mActive));
    checkOutput("left_start", int'(leftStart), int'(mActive && n == mLaunch));
    checkOutput("right_start", int'(rightStart), int'(mActive && n == mLaunch));
    checkOutput("res_valid", int'(resValid), int'(expValid));
    checkOutput("drop_cnt", int'(dropCnt), mDrops);
    if (expValid) begin
      checkOutput("bw", int'(bw), mBw);
      checkOutput("center", int'(center), mCenter);
      checkOutput("err", int'(err), mErr);
    end

    if (!mActive) begin
      if (frameReady && enable) begin
        mAccepted++;
        if (mAccepted % MDECIM == 0) begin
          mActive = 1'b1; mLaunch = n + 1; mDone = -1; mGotL = 1'b0; mGotR = 1'b0;
        end
      end
    end else begin
      if (frameReady && enable && mDrops < DROP_MAX) mDrops++;
      if (mDone < 0 && n >= mLaunch + 1) begin
        if (leftValid) begin mGotL = 1'b1; mL = int'(fLeft); end
        if (rightValid) begin mGotR = 1'b1; mR = int'(fRight); end
        if (mGotL && mGotR) begin
          mDone = n + 2; modelResult(1'b0);
        end else if (n == mLaunch + TO) begin
          mDone = n + 2; modelResult(1'b1);
        end
      end else if (mDone >= 0 && n >= mDone && resReady) begin
        mActive = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    modelStep();
    if (d3LeftStart) d3Starts++;
    @(posedge clk);
    #1;
    frameReady = 1'b0;
    leftValid  = 1'b0;
    rightValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input bit frame, input bit lv, input int fl, input bit rv, input int fr);
    frameReady = frame;
    leftValid  = lv;
    fLeft      = FW'(fl);
    rightValid = rv;
    fRight     = FW'(fr);
    tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    d3Starts = 0;
  endtask

  // Frame, both edges together two cycles later; leaves the bench in the HOLD cycle.
  task automatic quickMeasure(input int fl, input int fr);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    tick();
    applyStimulus(1'b0, 1'b1, fl, 1'b1, fr);
    tick();
  endtask

  initial begin
    int t;
    int lat;
    bit launched;
    modelReset();
    idle(3);
    rst = 1'b0;
    checkOutput("post-reset busy", int'(busy), 0);
    checkOutput("post-reset drop", int'(dropCnt), 0);
    enable = 1'b1;
    resReady = 1'b1;
    idle(2);

    // Nominal: left at t+5, right at t+9, result at t+11.
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    checkOutput("nom left_start", int'(leftStart), 1);
    checkOutput("nom right_start", int'(rightStart), 1);
    idle(4);
    applyStimulus(1'b0, 1'b1, 100, 1'b0, 0);
    idle(3);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 140);
    checkOutput("nom calc valid", int'(resValid), 0);
    tick();
    checkOutput("nom valid", int'(resValid), 1);
    checkOutput("nom bw", int'(bw), 40);
    checkOutput("nom center", int'(center), 120);
    checkOutput("nom err", int'(err), 0);
    tick();
    checkOutput("nom transfer", int'(resValid), 0);
    checkOutput("nom idle", int'(busy), 0);
    idle(2);

    // Same-cycle valids, then five cycles of backpressure with three dropped frames.
    doReset();
    resReady = 1'b0;
    quickMeasure(10, 11);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp valid", int'(resValid), 1);
      checkOutput("bp bw", int'(bw), 1);
      checkOutput("bp center", int'(center), 10);
      if (i % 2 == 0) applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
      else tick();
    end
    resReady = 1'b1;
    checkOutput("bp drops", int'(dropCnt), 3);
    checkOutput("bp still valid", int'(resValid), 1);
    tick();
    checkOutput("bp released", int'(resValid), 0);
    idle(2);

    // Timeout: only the left edge answers.
    t = cyc;
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    tick();
    applyStimulus(1'b0, 1'b1, 33, 1'b0, 0);
    for (int i = 0; i < 80 && !resValid; i++) tick();
    lat = cyc - t;
    checkOutput("timeout latency", lat, 67);
    checkOutput("timeout err", int'(err), 1);
    checkOutput("timeout bw", int'(bw), 0);
    checkOutput("timeout center", int'(center), 0);
    tick();
    checkOutput("timeout done", int'(busy), 0);
    idle(2);

    // Edge order error, top-bin edges, and odd sum flooring.
    quickMeasure(200, 150);
    checkOutput("order err", int'(err), 2);
    checkOutput("order bw", int'(bw), 0);
    checkOutput("order center", int'(center), 0);
    idle(2);
    quickMeasure(511, 511);
    checkOutput("max err", int'(err), 0);
    checkOutput("max bw", int'(bw), 0);
    checkOutput("max center", int'(center), 511);
    idle(2);
    quickMeasure(3, 8);
    checkOutput("floor bw", int'(bw), 5);
    checkOutput("floor center", int'(center), 5);
    idle(2);

    // Decimation by 3 on the second instance, with enable-low frames mixed in.
    doReset();
    for (int k = 1; k <= 6; k++) begin
      launched = (k % 3 == 0);
      applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
      checkOutput("decim start", int'(d3LeftStart & d3RightStart), int'(launched));
      checkOutput("decim busy", int'(d3Busy), int'(launched));
      tick();
      applyStimulus(1'b0, 1'b1, 50, 1'b1, 60);
      tick();
      checkOutput("decim valid", int'(d3ResValid), int'(launched));
      if (launched) begin
        checkOutput("decim bw", int'(d3Bw), 10);
        checkOutput("decim center", int'(d3Center), 55);
        checkOutput("decim err", int'(d3Err), 0);
      end
      if (k == 5) begin
        enable = 1'b0;
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
        enable = 1'b1;
      end else begin
        tick();
      end
      tick();
      if (k == 2 || k == 4) begin
        enable = 1'b0;
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
        enable = 1'b1;
        tick();
      end
      if (k == 2) checkOutput("decim count k2", d3Starts, 0);
      if (k == 3) checkOutput("decim count k3", d3Starts, 1);
    end
    checkOutput("decim launches", d3Starts, 2);
    checkOutput("decim drop d1", int'(dropCnt), 0);
    checkOutput("decim drop d3", int'(d3Drop), 0);
    idle(2);

    // Asynchronous reset in the middle of WAIT.
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    tick();
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    checkOutput("pre-reset drop", int'(dropCnt), 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async busy", int'(busy), 0);
    checkOutput("async valid", int'(resValid), 0);
    checkOutput("async drop", int'(dropCnt), 0);
    modelReset();
    d3Starts = 0;
    #1 rst = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b1, 70, 1'b1, 90);
    checkOutput("stale valids", int'(busy), 0);
    idle(2);
    quickMeasure(70, 90);
    checkOutput("relaunch valid", int'(resValid), 1);
    checkOutput("relaunch bw", int'(bw), 20);
    checkOutput("relaunch center", int'(center), 80);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
